request_dispatcher: RTL

//  Requester-side companion to the 16-way fixed-priority grant resolver (bit 0 highest).
//  - Latches one-cycle request pulses from up to N sources into a pending vector.
//  - Drives that vector to the resolver as requestSignals and takes back its one-hot grantSignals.
//  - Encodes the granted bit to an index and offers it downstream on a valid/ready handshake.
//  - Clears the served pending bit on acceptance, so a source is served once per pulse.

---
 rtl/request_dispatcher.sv | 110 +++++++++++
 1 files changed

// File: rtl/request_dispatcher.sv
// request_dispatcher: collects one-cycle request pulses into a pending vector,
// hands that vector to an external fixed-priority resolver, encodes the
// returned one-hot grant into an index and offers it downstream on a
// valid/ready handshake. Accepting an offer retires that source's pending bit.
module request_dispatcher #(
   parameter int N     = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic [N-1:0]     reqPulse,
   output logic [N-1:0]     requestSignals,
   input  logic [N-1:0]     grantSignals,
   output logic             dispValid,
   output logic [IDX_W-1:0] dispIndex,
   input  logic             dispReady,
   output logic [N-1:0]     overflowFlags,
   output logic             grantError,
   input  logic             clearFlags
);

   typedef enum logic {IDLE, OFFER} state_t;

   state_t         state;
   logic [N-1:0]   pending;
   logic [N-1:0]   ovf;
   logic [N-1:0]   clr;
   logic [N-1:0]   ovf_set;
   logic           accept;
   logic           grant_legal;
   logic           err_set;

   // True when exactly one bit of v is set
   function automatic logic is_onehot(input logic [N-1:0] v);
      return (v != '0) && ((v & (v - N'(1))) == '0);
   endfunction

   // Binary position of the set bit of a one-hot vector
   function automatic logic [IDX_W-1:0] encode(input logic [N-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (v[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   // A handshake retires exactly the source currently on offer
   assign accept      = dispValid & dispReady;
   assign clr         = accept ? (N'(1) << dispIndex) : '0;
   // A pulse on a bit still pending (and not being retired) is a lost request
   assign ovf_set     = reqPulse & pending & ~clr;
   assign grant_legal = is_onehot(grantSignals) && ((grantSignals & pending) != '0);
   assign err_set     = (state == IDLE) && (pending != '0) && !grant_legal;

   assign requestSignals = pending;
   assign overflowFlags  = ovf;

   // Pending vector: retire on accept, a same-cycle pulse re-arms the bit
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clr) | reqPulse;
      end
   end

   // Sticky error flags: a set condition beats a same-cycle clear
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         ovf        <= '0;
         grantError <= 1'b0;
      end else begin
         ovf        <= (clearFlags ? '0 : ovf) | ovf_set;
         grantError <= (clearFlags ? 1'b0 : grantError) | err_set;
      end
   end

   // Offer FSM: latch a legal grant in IDLE, hold it in OFFER until accepted
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state     <= IDLE;
         dispValid <= 1'b0;
         dispIndex <= '0;
      end else begin
         case (state)
            IDLE: begin
               if ((pending != '0) && grant_legal) begin
                  dispIndex <= encode(grantSignals);
                  dispValid <= 1'b1;
                  state     <= OFFER;
               end else begin
                  dispValid <= 1'b0;
               end
            end
            OFFER: begin
               if (dispReady) begin
                  dispValid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               dispValid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
